// File: rtl/aes_loopback_checker.sv
// Loopback checker: queues plaintext beats seen on the cipher input tap and
// compares them, in order, with the inverse-cipher output stream.
module aes_loopback_checker #(
    parameter int TDATA_WIDTH = 128,
    parameter int FIFO_DEPTH  = 32,
    parameter int CNT_WIDTH   = 32
) (
    input  logic                         clk,
    input  logic                         resetn,
    input  logic [TDATA_WIDTH-1:0]       ref_tdata,
    input  logic                         ref_tvalid,
    input  logic                         ref_tlast,
    input  logic                         ref_tready,
    input  logic [TDATA_WIDTH-1:0]       chk_in_tdata,
    input  logic                         chk_in_tvalid,
    input  logic                         chk_in_tlast,
    output logic                         chk_in_tready,
    input  logic                         clear_i,
    output logic [CNT_WIDTH-1:0]         pass_count_o,
    output logic [CNT_WIDTH-1:0]         fail_count_o,
    output logic                         overflow_o,
    output logic                         last_err_o,
    output logic [TDATA_WIDTH-1:0]       first_fail_data_o,
    output logic [CNT_WIDTH-1:0]         first_fail_idx_o,
    output logic [$clog2(FIFO_DEPTH):0]  pending_o,
    output logic [1:0]                   state_o,
    output logic                         error_o
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);
    localparam logic [AW:0] ONE_C   = (AW+1)'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                 state;
    logic [TDATA_WIDTH:0]   mem [FIFO_DEPTH];
    logic [AW-1:0]          wr_ptr;
    logic [AW-1:0]          rd_ptr;
    logic [AW:0]            count;

    logic                   full;
    logic                   empty;
    logic                   capture;
    logic                   pop;
    logic                   push;
    logic                   drop;
    logic                   match;
    logic                   head_last;
    logic [TDATA_WIDTH-1:0] head_data;
    logic [CNT_WIDTH-1:0]   beat_idx;

    assign full          = (count == DEPTH_C);
    assign empty         = (count == '0);
    assign capture       = ref_tvalid & ref_tready & ~clear_i;
    assign chk_in_tready = ~empty & ~clear_i;
    assign pop           = chk_in_tvalid & chk_in_tready;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign push          = capture & (~full | pop);
    assign drop          = capture & full & ~pop;

    assign {head_last, head_data} = mem[rd_ptr];
    assign match    = (chk_in_tdata == head_data);
    assign beat_idx = pass_count_o + fail_count_o;

    assign pending_o = count;
    assign state_o   = state;
    assign error_o   = (fail_count_o != '0) | overflow_o | last_err_o;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {ref_tlast, ref_tdata};
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr            <= '0;
            rd_ptr            <= '0;
            count             <= '0;
            pass_count_o      <= '0;
            fail_count_o      <= '0;
            overflow_o        <= 1'b0;
            last_err_o        <= 1'b0;
            first_fail_data_o <= '0;
            first_fail_idx_o  <= '0;
            state             <= IDLE;
        end else if (clear_i) begin
            wr_ptr            <= '0;
            rd_ptr            <= '0;
            count             <= '0;
            pass_count_o      <= '0;
            fail_count_o      <= '0;
            overflow_o        <= 1'b0;
            last_err_o        <= 1'b0;
            first_fail_data_o <= '0;
            first_fail_idx_o  <= '0;
            state             <= IDLE;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      count <= count + ONE_C;
            else if (pop && !push) count <= count - ONE_C;

            if (drop) overflow_o <= 1'b1;

            if (pop) begin
                if (match) begin
                    if (pass_count_o != '1) pass_count_o <= pass_count_o + 1'b1;
                end else begin
                    // A zero fail count means this is the first miss since clear.
                    if (fail_count_o == '0) begin
                        first_fail_data_o <= chk_in_tdata;
                        first_fail_idx_o  <= beat_idx;
                    end
                    if (fail_count_o != '1) fail_count_o <= fail_count_o + 1'b1;
                end
                if (chk_in_tlast != head_last) last_err_o <= 1'b1;
            end

            case (state)
                IDLE: if (capture) state <= RUN;
                RUN: begin
                    if (pop && chk_in_tlast && count == ONE_C && !capture)
                        state <= DONE;
                end
                DONE: if (capture) state <= RUN;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/aes_loopback_checker.md
AES_LOOPBACK_CHECKER -- requirements
Module: aes_loopback_checker

Interface
REQ-001 SHALL have parameter TDATA_WIDTH, default 128, the stream data width in bits.
REQ-002 SHALL have parameter FIFO_DEPTH, default 32, the expected-data FIFO depth in entries; power of two, at least 4.
REQ-003 SHALL have parameter CNT_WIDTH, default 32, the width of the pass and fail counters.
REQ-004 SHALL have port clk, input, 1 bit: single clock for all logic.
REQ-005 SHALL have port resetn, input, 1 bit: reset, asynchronous and active-low.
REQ-006 SHALL have ports ref_tdata (input, TDATA_WIDTH), ref_tvalid (input, 1), ref_tlast (input, 1) and ref_tready (input, 1): passive monitor tap on the plaintext stream entering the cipher.
REQ-007 SHALL have ports chk_in_tdata (input, TDATA_WIDTH), chk_in_tvalid (input, 1) and chk_in_tlast (input, 1): AXI-Stream slave carrying the inverse-cipher output.
REQ-008 SHALL have port chk_in_tready, output, 1 bit: ready for the chk_in stream.
REQ-009 SHALL have port clear_i, input, 1 bit: synchronous clear pulse.
REQ-010 SHALL have ports pass_count_o and fail_count_o, output, CNT_WIDTH each: number of matching and mismatching beats.
REQ-011 SHALL have ports overflow_o and last_err_o, output, 1 bit each: sticky error flags.
REQ-012 SHALL have ports first_fail_data_o (output, TDATA_WIDTH) and first_fail_idx_o (output, CNT_WIDTH): data and beat index of the first mismatch.
REQ-013 SHALL have ports pending_o (output, log2(FIFO_DEPTH)+1 bits), state_o (output, 2 bits) and error_o (output, 1 bit).

Function
REQ-014 A ref beat SHALL be captured when ref_tvalid and ref_tready are both 1; the checker SHALL never drive the ref stream.
REQ-015 Each captured ref beat SHALL push {ref_tlast, ref_tdata} into the FIFO.
REQ-016 chk_in_tready SHALL equal (FIFO not empty) and (not clear_i).
REQ-017 A chk beat SHALL be accepted when chk_in_tvalid and chk_in_tready are both 1, and SHALL pop the FIFO head in the same cycle.
REQ-018 An accepted chk beat SHALL be a pass when chk_in_tdata equals the head data, otherwise a fail.
REQ-019 On a fail, fail_count_o SHALL increment; on a pass, pass_count_o SHALL increment.
REQ-020 Both counters SHALL update on the clock edge after acceptance (one-cycle registered latency).
REQ-021 Both counters SHALL saturate at all-ones and never wrap.
REQ-022 When chk_in_tlast differs from the head's tlast, last_err_o SHALL be set sticky, independent of the data compare result.
REQ-023 On the first fail since reset or clear, first_fail_data_o SHALL capture chk_in_tdata.
REQ-024 On that same first fail, first_fail_idx_o SHALL capture pass_count plus fail_count taken before the update, i.e. the 0-based beat index.
REQ-025 first_fail_data_o and first_fail_idx_o SHALL hold until reset or clear.
REQ-026 FIFO full with a push and no pop: the ref beat SHALL be dropped and overflow_o set sticky.
REQ-027 FIFO full with a push and a simultaneous pop: both SHALL occur, occupancy SHALL stay unchanged, and no overflow SHALL be flagged.
REQ-028 pending_o SHALL equal FIFO occupancy, 0..FIFO_DEPTH; read and write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-029 error_o SHALL be 1 when (fail_count_o != 0) or overflow_o or last_err_o.
REQ-030 The state machine SHALL be IDLE=0, RUN=1, DONE=2, shown on state_o.
REQ-031 IDLE SHALL go to RUN on the first ref capture.
REQ-032 RUN SHALL go to DONE when an accepted chk beat has tlast=1 and the FIFO becomes empty after the pop with no simultaneous push.
REQ-033 DONE SHALL go to RUN on the next ref capture.
REQ-034 Counters and flags SHALL persist through DONE; DONE SHALL be informational only.
REQ-035 clear_i=1 SHALL empty the FIFO, zero all counters, flags and capture registers, and force IDLE on the next edge.
REQ-036 While clear_i=1, ref beats in the same cycle SHALL be discarded.
REQ-037 clear_i SHALL take priority over every simultaneous event.

Reset
REQ-038 While resetn=0, chk_in_tready, both counters, overflow_o, last_err_o, first_fail_data_o, first_fail_idx_o, pending_o and error_o SHALL all be 0, and state_o SHALL be IDLE.
REQ-039 Reset assertion mid-stream SHALL discard FIFO contents immediately, without waiting for a clock edge.
REQ-040 After resetn deasserts, the block SHALL operate from the first rising clk edge.

Verification
REQ-041 Push 4 ref beats 0x0..01..0x0..04 (last on 4th), return identical chk beats -> pass_count=4, fail_count=0, state DONE, error_o=0.
REQ-042 Same ref beats; 3rd chk beat = 0xDEAD..BEEF -> fail_count=1, pass_count=3, first_fail_idx=2, first_fail_data=0xDEAD..BEEF, error_o=1.
REQ-043 With chk_in_tvalid=0, push 33 ref beats -> pending_o=32, overflow_o=1; with push and pop in the same cycle at full -> pending_o stays 32 and no new drop occurs.
REQ-044 chk beat with matching data but tlast=0 where ref tlast=1 -> last_err_o=1, pass_count increments, state remains RUN.
REQ-045 resetn pulsed low mid-stream with pending_o=5 -> all outputs 0 asynchronously; pulse clear_i with pending_o=3 -> on the next edge pending_o=0, counters=0, state IDLE.
REQ-046 Force fail_count to all-ones, then send one mismatch -> fail_count_o remains all-ones.
